shift_arbiter: RTL and testbench

// - Shares one 32-bit left barrel shifter (shift_left_logical) between two requesters.
// - Round-robin arbitration with valid/ready on each request port and on the single result port.
// - SRL is done by reversing the bits, shifting left, then reversing back.
// - SRA adds a second shifter pass that builds the sign-fill mask.
// - Sits between ALU issue logic and the shared shifter in the datapath.

---
 rtl/shift_arbiter_pkg.sv | 31 +++
 rtl/shift_arbiter_if.sv | 45 ++++
 rtl/shift_arbiter_shl.sv | 25 ++
 rtl/shift_arbiter.sv | 147 ++++++++++++++
 tb/tb_shift_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared types and helpers for the shift arbiter: operation and FSM state
// encodings plus a 32-bit bit-reversal used to build right shifts on a
// left-only shifter.
package shift_pkg;

  localparam int unsigned DataW  = 32;
  localparam int unsigned ShamtW = $clog2(DataW);

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MASK  = 2'd2,
    HOLD  = 2'd3
  } shift_arb_state_t;

  // Mirror a word end to end so a left shift behaves as a right shift.
  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle of the shift arbiter: two valid/ready request ports
// and one valid/ready result port. The master side drives requests and
// accepts results; the slave side is the arbiter.
interface shift_arbiter_if #(
  parameter int unsigned N = 32
);

  localparam int unsigned SW = $clog2(N);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][N-1:0]      req_data;
  logic [1:0][SW-1:0]     req_shamt;
  logic [1:0][1:0]        req_op;

  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0]           out_data;
  logic                   out_id;

  modport master (
    output req_valid,
    output req_data,
    output req_shamt,
    output req_op,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_shamt,
    input  req_op,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id
  );

endinterface

// File: rtl/shift_arbiter_shl.sv
// Logarithmic left barrel shifter: one conditional power-of-two stage per
// bit of the shift amount, zero fill from the right.
module shift_left_logical #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]         operand,
  input  logic [$clog2(N)-1:0] amount,
  output logic [N-1:0]         result
);

  localparam int unsigned SW = $clog2(N);

  // Walk the stages from the 1-bit shift up to the N/2-bit shift.
  always_comb begin
    logic [N-1:0] acc;
    acc = operand;
    for (int i = 0; i < SW; i++) begin
      if (amount[i]) begin
        acc = acc << (32'd1 << i);
      end
    end
    result = acc;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit left
// shifter. Right shifts are built by reversing the operand, shifting left,
// and reversing the raw result back.
//
// Build option: define SHIFT_ARBITER_SRA_EN to make OP_SRA an arithmetic
// shift. That adds a MASK pass which reuses the shifter on an all-ones word
// to find the vacated high bits, then ORs in the sign. Without the macro
// OP_SRA runs exactly as OP_SRL.
module shift_arbiter
  import shift_pkg::*;
(
  input logic            clk,
  input logic            rst,
  shift_arbiter_if.slave bus
);

  shift_arb_state_t    state_q, state_d;
  logic                prio_q, prio_d;
  logic                id_q, id_d;
  logic [DataW-1:0]    data_q, data_d;
  logic [DataW-1:0]    result_q, result_d;
  logic [ShamtW-1:0]   shamt_q, shamt_d;
  shift_op_t           op_q, op_d;

  logic                grant;
  logic                accept;
  logic                is_right;
  logic                needs_mask;
  logic [DataW-1:0]    shift_in;
  logic [DataW-1:0]    shift_raw;

  // Reserved op 2'b11 falls through to a left shift.
  assign is_right = (op_q == OP_SRL) || (op_q == OP_SRA);

`ifdef SHIFT_ARBITER_SRA_EN
  assign needs_mask = (op_q == OP_SRA);
`else
  assign needs_mask = 1'b0;
`endif

  // Grant the sole valid requester, or the priority holder when both ask.
  always_comb begin
    grant = prio_q;
    if (bus.req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  // Ready goes only to the granted requester, and only while idle.
  always_comb begin
    bus.req_ready = 2'b00;
    if ((state_q == IDLE) && (bus.req_valid != 2'b00)) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  assign accept = (state_q == IDLE) && bus.req_valid[grant];

  // Select what the shared shifter sees in each phase.
  always_comb begin
    shift_in = data_q;
    unique case (state_q)
      SHIFT: shift_in = is_right ? bitrev32(data_q) : data_q;
`ifdef SHIFT_ARBITER_SRA_EN
      MASK:  shift_in = '1;
`endif
      default: shift_in = data_q;
    endcase
  end

  shift_left_logical #(
    .N(DataW)
  ) u_shl (
    .operand(shift_in),
    .amount (shamt_q),
    .result (shift_raw)
  );

  // Next-state and datapath updates for IDLE -> SHIFT -> (MASK) -> HOLD.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    data_d   = data_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    op_d     = op_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.req_data[grant];
          shamt_d = bus.req_shamt[grant];
          op_d    = shift_op_t'(bus.req_op[grant]);
          id_d    = grant;
          prio_d  = ~grant;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        result_d = is_right ? bitrev32(shift_raw) : shift_raw;
        state_d  = needs_mask ? MASK : HOLD;
      end
      MASK: begin
`ifdef SHIFT_ARBITER_SRA_EN
        // Bits cleared in the reversed all-ones shift are the vacated MSBs.
        result_d = result_q | (~bitrev32(shift_raw) & {DataW{data_q[DataW-1]}});
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      op_q     <= OP_SLL;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      data_q   <= data_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = result_q;
  assign bus.out_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed and random operations
// against an arithmetic reference model, fairness, backpressure and reset.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_arbiter_if #(.N(32)) bus ();

  shift_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   passed = 0;
  int   total  = 0;
  logic exp_prio;

  // Reference result from the shift definitions themselves.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd1: r = d >> s;
`ifdef SHIFT_ARBITER_SRA_EN
      2'd2: r = $unsigned($signed(d) >>> s);
`else
      2'd2: r = d >> s;
`endif
      default: r = d << s;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef SHIFT_ARBITER_SRA_EN
    if (op == 2'd2) return 2;
`endif
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_prio = 1'b0;
  endtask

  // Issue one request on a single port and check grant, latency and result.
  task automatic run_op(input int id, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input string name);
    int          n;
    logic [31:0] want;
    want = model(d, s, op);
    bus.req_data[id]  = d;
    bus.req_shamt[id] = s;
    bus.req_op[id]    = op;
    bus.req_valid[id] = 1'b1;
    n = 0;
    while (bus.req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bus.req_ready[id] !== 1'b1) begin
      $display("FAIL %s grant: req_ready=%b, required bit %0d set", name, bus.req_ready, id);
      bus.req_valid[id] = 1'b0;
      return;
    end
    passed++;
    tick();
    bus.req_valid[id] = 1'b0;
    exp_prio = (id == 0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== exp_lat(op))
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat(op));
    else passed++;
    total++;
    if (bus.out_data !== want)
      $display("FAIL %s data: got %h, required %h (d=%h s=%0d op=%0d)", name, bus.out_data,
               want, d, s, op);
    else passed++;
    total++;
    if (bus.out_id !== id[0])
      $display("FAIL %s id: got %b, required %0d", name, bus.out_id, id);
    else passed++;
    tick();
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b, required 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.out_data !== 32'h0) $display("FAIL reset out_data: got %h, required 0", bus.out_data);
    else passed++;
    total++;
    if (bus.out_id !== 1'b0) $display("FAIL reset out_id: got %b, required 0", bus.out_id);
    else passed++;
    total++;
    if (bus.req_ready !== 2'b00) $display("FAIL reset req_ready: got %b, required 00", bus.req_ready);
    else passed++;
    rst = 1'b0;
    tick();
    bus.req_valid = 2'b11;
    #1;
    total++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL reset prio: req_ready=%b, required 01", bus.req_ready);
    else passed++;
    bus.req_valid = 2'b00;
    exp_prio = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d;
    run_op(0, 32'h0000_00F1, 5'd4, 2'd0, "sll");
    run_op(1, 32'h8000_0001, 5'd31, 2'd1, "srl");
    run_op(0, 32'hF000_0000, 5'd4, 2'd2, "sra");
    d = $urandom;
    for (int op = 0; op < 4; op++) run_op(1, d, 5'd0, op[1:0], "shamt0");
    run_op(0, 32'hA5C3_0F0F, 5'd31, 2'd0, "sll31");
    run_op(1, 32'hA5C3_0F0F, 5'd31, 2'd1, "srl31");
    run_op(0, 32'h8000_0000, 5'd31, 2'd2, "sra31");
    run_op(1, 32'h1234_5678, 5'd7, 2'd3, "reserved");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_fairness();
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;
    logic        exp_id;
    int          got, last, cyc;
    do_reset();
    d0 = $urandom;
    d1 = $urandom;
    s0 = 5'($urandom_range(1, 31));
    s1 = 5'($urandom_range(1, 31));
    bus.req_data[0] = d0; bus.req_shamt[0] = s0; bus.req_op[0] = 2'd0;
    bus.req_data[1] = d1; bus.req_shamt[1] = s1; bus.req_op[1] = 2'd1;
    bus.req_valid = 2'b11;
    exp_id = exp_prio;
    got = 0;
    last = 0;
    cyc = 0;
    while (got < 6 && cyc < 80) begin
      tick();
      cyc++;
      if (bus.out_valid === 1'b1) begin
        total++;
        if (bus.out_id !== exp_id)
          $display("FAIL fair id #%0d: got %b, required %b", got, bus.out_id, exp_id);
        else passed++;
        total++;
        if (bus.out_data !== (exp_id ? model(d1, s1, 2'd1) : model(d0, s0, 2'd0)))
          $display("FAIL fair data #%0d: got %h, required %h", got, bus.out_data,
                   exp_id ? model(d1, s1, 2'd1) : model(d0, s0, 2'd0));
        else passed++;
        if (got > 0) begin
          total++;
          if (cyc - last != 3)
            $display("FAIL fair gap #%0d: got %0d cycles, required 3", got, cyc - last);
          else passed++;
        end
        last = cyc;
        exp_prio = ~exp_id;
        exp_id = ~exp_id;
        got++;
        if (got == 6) bus.req_valid = 2'b00;
      end
    end
    bus.req_valid = 2'b00;
    total++;
    if (got != 6) $display("FAIL fair count: got %0d results, required 6", got);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] d, want;
    int          n;
    d = $urandom;
    want = model(d, 5'd9, 2'd0);
    bus.out_ready = 1'b0;
    bus.req_data[0] = d; bus.req_shamt[0] = 5'd9; bus.req_op[0] = 2'd0;
    bus.req_data[1] = $urandom; bus.req_shamt[1] = 5'd3; bus.req_op[1] = 2'd1;
    bus.req_valid = 2'b01;
    n = 0;
    while (bus.req_ready[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.req_valid = 2'b11;
    exp_prio = 1'b1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL bp valid c%0d: got %b, required 1", c, bus.out_valid);
      else passed++;
      total++;
      if (bus.out_data !== want) $display("FAIL bp data c%0d: got %h, required %h", c, bus.out_data, want);
      else passed++;
      total++;
      if (bus.out_id !== 1'b0) $display("FAIL bp id c%0d: got %b, required 0", c, bus.out_id);
      else passed++;
      total++;
      if (bus.req_ready !== 2'b00) $display("FAIL bp ready c%0d: got %b, required 00", c, bus.req_ready);
      else passed++;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.req_ready !== (exp_prio ? 2'b10 : 2'b01))
      $display("FAIL bp rearb: req_ready=%b, required %b", bus.req_ready,
               exp_prio ? 2'b10 : 2'b01);
    else passed++;
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.out_ready = 1'b1;
    bus.req_data[0] = 32'hDEAD_BEEF; bus.req_shamt[0] = 5'd5; bus.req_op[0] = 2'd0;
    bus.req_valid = 2'b01;
    n = 0;
    while (bus.req_ready[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_data !== 32'h0) $display("FAIL rst_mid data: got %h, required 0", bus.out_data);
    else passed++;
    tick();
    rst = 1'b0;
    exp_prio = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_mid valid c%0d: got %b, required 0", c, bus.out_valid);
      else passed++;
      tick();
    end
    bus.req_valid = 2'b11;
    #1;
    total++;
    if (bus.req_ready !== 2'b01) $display("FAIL rst_mid idle: req_ready=%b, required 01", bus.req_ready);
    else passed++;
    bus.req_valid = 2'b00;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_data  = '0;
    bus.req_shamt = '0;
    bus.req_op    = '0;
    bus.out_ready = 1'b1;
    exp_prio      = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
